// File: rtl/conv_stream_ctrl.sv
// Sequencer that streams kernel and image columns into a systolic PE array,
// one channel at a time, and tags each image beat with output/accumulate qualifiers.
module conv_stream_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1,
    parameter int NUM_CH      = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    output logic                                 o_busy,
    output logic                                 o_done,
    input  logic                                 i_k_valid,
    output logic                                 o_k_ready,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]    i_k_data,
    input  logic                                 i_img_valid,
    output logic                                 o_img_ready,
    input  logic [IMAGE_SIZE*DATA_WIDTH-1:0]     i_img_data,
    output logic [IMAGE_SIZE*DATA_WIDTH-1:0]     o_pe_data,
    output logic                                 o_pe_kernel_load,
    output logic                                 o_pe_valid_in,
    output logic                                 o_pe_out_en,
    output logic                                 o_pe_acc_clear,
    output logic                                 o_pe_last_ch,
    output logic [$clog2(NUM_CH):0]              o_ch_idx,
    output logic [$clog2(IMAGE_SIZE):0]          o_out_col
);

    localparam int PEW  = IMAGE_SIZE * DATA_WIDTH;
    localparam int KCW  = $clog2(KERNEL_SIZE + 1);
    localparam int COLW = $clog2(IMAGE_SIZE + 1);
    localparam int PHW  = $clog2(STRIDE + 1);
    localparam int CHW  = $clog2(NUM_CH) + 1;
    localparam int OCW  = $clog2(IMAGE_SIZE) + 1;

    localparam logic [KCW-1:0]  K_LAST    = KCW'(KERNEL_SIZE - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(IMAGE_SIZE - 1);
    localparam logic [COLW-1:0] COL_FIRST = COLW'(KERNEL_SIZE - 1);
    localparam logic [PHW-1:0]  PH_LAST   = PHW'(STRIDE - 1);
    localparam logic [CHW-1:0]  CH_LAST   = CHW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KERNEL,
        S_STREAM_IMAGE,
        S_NEXT_CH,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [KCW-1:0]    r_kcnt;
    logic [COLW-1:0]   r_col;
    logic [PHW-1:0]    r_phase;
    logic [CHW-1:0]    r_ch_idx;
    logic [OCW-1:0]    r_out_cnt;

    logic [PEW-1:0]    r_pe_data;
    logic              r_pe_kernel_load;
    logic              r_pe_valid_in;
    logic              r_pe_out_en;
    logic              r_pe_acc_clear;
    logic              r_pe_last_ch;
    logic [OCW-1:0]    r_pe_out_col;

    logic              w_k_xfer;
    logic              w_img_xfer;
    logic              w_k_last;
    logic              w_img_last;
    logic              w_col_past_edge;
    logic              w_col_out;
    logic              w_ch_last;

    assign w_k_xfer        = i_k_valid && (r_state == S_LOAD_KERNEL);
    assign w_img_xfer      = i_img_valid && (r_state == S_STREAM_IMAGE);
    assign w_k_last        = w_k_xfer && (r_kcnt == K_LAST);
    assign w_img_last      = w_img_xfer && (r_col == COL_LAST);
    // r_phase only advances once the kernel window fits, so phase 0 marks a stride-aligned column
    assign w_col_past_edge = (r_col >= COL_FIRST);
    assign w_col_out       = w_col_past_edge && (r_phase == '0);
    assign w_ch_last       = (r_ch_idx == CH_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_LOAD_KERNEL;
                end
            end
            S_LOAD_KERNEL: begin
                if (w_k_last) begin
                    w_next_state = S_STREAM_IMAGE;
                end
            end
            S_STREAM_IMAGE: begin
                if (w_img_last) begin
                    w_next_state = S_NEXT_CH;
                end
            end
            S_NEXT_CH: begin
                w_next_state = w_ch_last ? S_FINISH : S_LOAD_KERNEL;
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_FINISH);
        o_k_ready   = (r_state == S_LOAD_KERNEL);
        o_img_ready = (r_state == S_STREAM_IMAGE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kcnt    <= '0;
            r_col     <= '0;
            r_phase   <= '0;
            r_ch_idx  <= '0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_kcnt    <= '0;
                        r_col     <= '0;
                        r_phase   <= '0;
                        r_ch_idx  <= '0;
                        r_out_cnt <= '0;
                    end
                end
                S_LOAD_KERNEL: begin
                    if (w_k_xfer) begin
                        r_kcnt <= w_k_last ? '0 : r_kcnt + KCW'(1);
                    end
                end
                S_STREAM_IMAGE: begin
                    if (w_img_xfer) begin
                        r_col <= w_img_last ? '0 : r_col + COLW'(1);
                        if (w_col_past_edge) begin
                            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PHW'(1);
                        end
                        if (w_col_out) begin
                            r_out_cnt <= r_out_cnt + OCW'(1);
                        end
                    end
                end
                S_NEXT_CH: begin
                    r_kcnt    <= '0;
                    r_col     <= '0;
                    r_phase   <= '0;
                    r_out_cnt <= '0;
                    if (!w_ch_last) begin
                        r_ch_idx <= r_ch_idx + CHW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every accepted beat is re-registered toward the PE array so no input reaches pe_* combinationally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pe_data        <= '0;
            r_pe_kernel_load <= 1'b0;
            r_pe_valid_in    <= 1'b0;
            r_pe_out_en      <= 1'b0;
            r_pe_acc_clear   <= 1'b0;
            r_pe_last_ch     <= 1'b0;
            r_pe_out_col     <= '0;
        end else begin
            r_pe_valid_in    <= w_k_xfer || w_img_xfer;
            r_pe_kernel_load <= w_k_xfer;
            r_pe_out_en      <= w_img_xfer && w_col_out;
            r_pe_acc_clear   <= w_img_xfer && w_col_out && (r_ch_idx == '0);
            r_pe_last_ch     <= w_img_xfer && w_col_out && w_ch_last;
            if (w_k_xfer) begin
                r_pe_data <= PEW'(i_k_data);
            end else if (w_img_xfer) begin
                r_pe_data <= i_img_data;
            end
            if (w_img_xfer && w_col_out) begin
                r_pe_out_col <= r_out_cnt;
            end
        end
    end

    assign o_pe_data        = r_pe_data;
    assign o_pe_kernel_load = r_pe_kernel_load;
    assign o_pe_valid_in    = r_pe_valid_in;
    assign o_pe_out_en      = r_pe_out_en;
    assign o_pe_acc_clear   = r_pe_acc_clear;
    assign o_pe_last_ch     = r_pe_last_ch;
    assign o_ch_idx         = r_ch_idx;
    assign o_out_col        = r_pe_out_col;

endmodule

// File: doc/conv_stream_ctrl.md
CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of one pixel/weight word.
REQ-002 Parameter KERNEL_SIZE, 5, kernel side K, legal range 2 to IMAGE_SIZE.
REQ-003 Parameter IMAGE_SIZE, 28, image side N, one column = N words.
REQ-004 Parameter STRIDE, 1, horizontal output stride S, legal range 1 to K.
REQ-005 Parameter NUM_CH, 1, input channels accumulated per output map.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  request a new job; sampled only in IDLE.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse at job end.
REQ-011 k_valid / k_ready / k_data  in/out/in  1/1/K*DATA_WIDTH  kernel column stream, word 0 in LSBs.
REQ-012 img_valid / img_ready / img_data  in/out/in  1/1/N*DATA_WIDTH  image column stream, word 0 in LSBs.
REQ-013 pe_data  out  N*DATA_WIDTH  registered column broadcast to the PE array.
REQ-014 pe_kernel_load  out  1  pe_data holds a kernel column.
REQ-015 pe_valid_in  out  1  pe_data is a new beat this cycle.
REQ-016 pe_out_en  out  1  PE array SHALL emit a result column on this beat.
REQ-017 pe_acc_clear / pe_last_ch  out  1/1  first-channel and last-channel qualifiers, valid with pe_out_en.
REQ-018 ch_idx / out_col  out  clog2(NUM_CH)+1 / clog2(N)+1  current channel and output-column index.

Function
REQ-019 States: IDLE, LOAD_KERNEL, STREAM_IMAGE, NEXT_CH, FINISH; encoding free.
REQ-020 IDLE->LOAD_KERNEL when start=1; busy=1, ch_idx=0 on that edge.
REQ-021 LOAD_KERNEL: k_ready=1, img_ready=0; each k_valid&k_ready beat is one transfer; after K transfers go to STREAM_IMAGE.
REQ-022 STREAM_IMAGE: img_ready=1, k_ready=0; after N transfers go to NEXT_CH.
REQ-023 NEXT_CH (one cycle): if ch_idx==NUM_CH-1 go to FINISH, else ch_idx+1 and go to LOAD_KERNEL.
REQ-024 FINISH (one cycle): done=1, busy=0 next cycle, return to IDLE.
REQ-025 Every accepted transfer SHALL appear on pe_data with pe_valid_in=1 exactly one cycle later; pe_valid_in=0 on all other cycles; pe_data holds its last value otherwise.
REQ-026 Kernel words zero-extended into the low K*DATA_WIDTH bits of pe_data; pe_kernel_load=1 with those beats only.
REQ-027 Image column c (0-based within channel): pe_out_en=1 iff c>=K-1 and (c-(K-1)) mod S==0; qualifiers registered with the beat.
REQ-028 Output columns per channel SHALL equal (N-K) div S + 1; out_col counts them 0.., resets per channel.
REQ-029 pe_acc_clear=1 with pe_out_en when ch_idx==0; pe_last_ch=1 with pe_out_en when ch_idx==NUM_CH-1; both 1 when NUM_CH=1.
REQ-030 Valid gaps SHALL stall counters with no lost, duplicated or reordered beats; valid without ready is ignored.
REQ-031 start while busy ignored; start held high through FINISH starts a new job from IDLE the next cycle.
REQ-032 Trailing columns not aligned to S (N-K not multiple of S) SHALL be streamed with pe_out_en=0.
REQ-033 No combinational path from any input to pe_* outputs.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, all counters 0, busy=done=k_ready=img_ready=0, pe_valid_in=pe_kernel_load=pe_out_en=pe_acc_clear=pe_last_ch=0, pe_data=0.
REQ-035 Reset mid-job SHALL abandon the job with no further pe_valid_in; first cycle after release is IDLE.

Verification
REQ-036 K=5,N=28,S=1,NUM_CH=1, continuous valids -> 5 kernel beats with pe_kernel_load, 28 image beats, 24 pe_out_en pulses with acc_clear and last_ch, out_col 0..23, one done.
REQ-037 S=2, same sizes -> 12 pe_out_en on columns 4,6,...,26; column 27 streamed with pe_out_en=0.
REQ-038 NUM_CH=3 -> three kernel+image passes, ch_idx 0,1,2; acc_clear only in ch 0, last_ch only in ch 2; 72 pe_out_en total; single done.
REQ-039 Random valid gaps (50%) -> pe_data beat sequence identical to gap-free run; counts as REQ-036.
REQ-040 rst=0 at image column 10 of channel 1 -> all outputs 0 asynchronously; new start runs a full job correctly.
REQ-041 start pulsed during STREAM_IMAGE -> ignored, exactly one done.
